// File: rtl/br_bias_loader.sv
// br_bias_loader
//   Fetches NUM_BIAS bias bytes from the bias memory over a 4-phase
//   readM/ready handshake and keeps them in an internal register file.
//   After a load, the branch datapath reads bytes back through rd_idx/rd_bias.
//
// Handshake: readM is raised to request a byte. The memory raises ready
//   with data stable. The byte is captured when the synchronised ready_s is
//   seen high. readM then drops, and the memory drops ready. The next request
//   starts only after ready_s is seen low again. A phase that lasts TIMEOUT
//   cycles aborts the load and sets the sticky err flag.
//
// Ports
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   start        : one-cycle load request (ignored while busy)
//   readM        : registered request to the bias memory
//   ready        : memory acknowledge (asynchronous, synchronised here)
//   data         : memory byte, stable while ready is high
//   rd_idx       : register-file read index
//   rd_bias      : bias[rd_idx], 8'h00 for an index >= NUM_BIAS
//   busy         : load in progress
//   done         : one-cycle pulse after the last byte is stored
//   loaded       : register file holds a complete vector
//   err          : sticky handshake-timeout flag
//   dbg_state    : current FSM state (0 idle, 1 req, 2 rel, 3 done)
module br_bias_loader #(
   parameter int NUM_BIAS = 256,
   parameter int IDX_W    = 8,
   parameter int TIMEOUT  = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             readM,
   input  logic             ready,
   input  logic [7:0]       data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [7:0]       rd_bias,
   output logic             busy,
   output logic             done,
   output logic             loaded,
   output logic             err,
   output logic [1:0]       dbg_state
);

   localparam int                TMR_W      = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_BIAS - 1);
   localparam logic [TMR_W-1:0]  TMR_MAX    = TMR_W'(TIMEOUT);
   localparam logic [IDX_W:0]    NUM_BIAS_X = (IDX_W + 1)'(NUM_BIAS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_REL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state, state_d;
   logic [IDX_W-1:0]  count, count_d;
   logic [TMR_W-1:0]  timer, timer_d;
   logic              ready_m, ready_s;
   logic              wr_en;
   logic              start_acc;
   logic              set_err;
   logic [7:0]        bias [NUM_BIAS];

   // Two-flop synchroniser for the asynchronous memory acknowledge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_m <= 1'b0;
         ready_s <= 1'b0;
      end else begin
         ready_m <= ready;
         ready_s <= ready_m;
      end
   end

   // Next-state logic. A timeout takes priority over a handshake edge seen
   // in the same cycle.
   always_comb begin
      state_d   = state;
      count_d   = count;
      wr_en     = 1'b0;
      start_acc = 1'b0;
      set_err   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               count_d   = '0;
               state_d   = S_REQ;
            end
         end
         S_REQ: begin
            if (timer == TMR_MAX) begin
               set_err = 1'b1;
               state_d = S_IDLE;
            end else if (ready_s) begin
               wr_en   = 1'b1;
               state_d = S_REL;
            end
         end
         S_REL: begin
            if (timer == TMR_MAX) begin
               set_err = 1'b1;
               state_d = S_IDLE;
            end else if (!ready_s) begin
               if (count == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  count_d = count + 1'b1;
                  state_d = S_REQ;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Phase timer: restarts on every state change, runs only while
      // waiting on the memory.
      timer_d = '0;
      if ((state_d == state) && ((state == S_REQ) || (state == S_REL)))
         timer_d = timer + 1'b1;
   end

   // State and registered outputs. readM follows the next state, so it
   // changes exactly on the edge that enters or leaves REQ.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         count  <= '0;
         timer  <= '0;
         readM  <= 1'b0;
         done   <= 1'b0;
         loaded <= 1'b0;
         err    <= 1'b0;
      end else begin
         state <= state_d;
         count <= count_d;
         timer <= timer_d;
         readM <= (state_d == S_REQ);
         done  <= (state == S_DONE);
         if (start_acc)
            loaded <= 1'b0;
         else if (state == S_DONE)
            loaded <= 1'b1;
         if (start_acc)
            err <= 1'b0;
         else if (set_err)
            err <= 1'b1;
      end
   end

   // Register file has no reset; partially written entries survive aborts.
   always_ff @(posedge clk) begin
      if (wr_en && !rst)
         bias[count] <= data;
   end

   always_comb begin
      rd_bias = 8'h00;
      if ({1'b0, rd_idx} < NUM_BIAS_X)
         rd_bias = bias[rd_idx];
   end

   assign busy      = (state != S_IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_br_bias_loader.sv
// Testbench for br_bias_loader with a small configuration (12 bytes,
// 4-bit index so out-of-range reads are reachable, 31-cycle timeout).
// The bias memory is a behavioural model with random response delays
// that fit inside one clock period and an address pointer without reset.
module tb_br_bias_loader;

   localparam int NB    = 12;
   localparam int IW    = 4;
   localparam int TO    = 31;
   localparam int MEMSZ = 64;
   localparam int LOAD_CYC = 6 * NB + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          ready = 1'b0;
   logic [7:0]    data = 8'h00;
   logic [IW-1:0] rd_idx = '0;
   logic          readM;
   logic [7:0]    rd_bias;
   logic          busy;
   logic          done;
   logic          loaded;
   logic          err;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int s_edge = 0;
   int rise_cnt = 0;

   // Memory model state
   logic [7:0] mem [MEMSZ];
   int         ptr = 0;
   int         mem_mode = 0;   // 0 normal, 1 never acknowledges, 2 ready stuck high after a byte

   // Reference model of the register-file contents
   logic [7:0] exp_bias [NB];

   br_bias_loader #(
      .NUM_BIAS (NB),
      .IDX_W    (IW),
      .TIMEOUT  (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .readM     (readM),
      .ready     (ready),
      .data      (data),
      .rd_idx    (rd_idx),
      .rd_bias   (rd_bias),
      .busy      (busy),
      .done      (done),
      .loaded    (loaded),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(posedge readM) rise_cnt++;

   // ---------------- memory model ----------------
   always begin
      int d;
      @(posedge readM);
      if (mem_mode != 1) begin
         d = $urandom_range(1, 4);
         #d;
         data  = mem[ptr % MEMSZ];
         ready = 1'b1;
         @(negedge readM);
         if (mem_mode != 2) begin
            d = $urandom_range(1, 4);
            #d;
            ready = 1'b0;
            data  = 8'($urandom);
            ptr++;
         end
      end
   end

   task automatic mem_reset();
      ptr      = 0;
      ready    = 1'b0;
      mem_mode = 0;
   endtask

   task automatic fill_random();
      for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
   endtask

   // Expected result of a complete load beginning at memory address p0.
   task automatic model_load(input int p0);
      for (int i = 0; i < NB; i++) exp_bias[i] = mem[(p0 + i) % MEMSZ];
   endtask

   // ---------------- driver tasks ----------------
   // Returns at the falling edge just after the start edge (cyc == s_edge).
   task automatic pulse_start();
      @(negedge clk);
      start  = 1'b1;
      s_edge = cyc + 1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_done(output int at);
      at = -1;
      for (int k = 0; k < 400; k++) begin
         if (done === 1'b1) begin
            at = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_done_timing(input string tag);
      int at;
      wait_done(at);
      checks++;
      if (at - s_edge != LOAD_CYC) begin
         errors++;
         $display("FAIL %s done_latency: got %0d expected %0d (at=%0d)", tag, at - s_edge, LOAD_CYC, at);
      end
      checks++;
      if (loaded !== 1'b1) begin
         errors++;
         $display("FAIL %s loaded_with_done: got %b expected 1", tag, loaded);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || loaded !== 1'b1) begin
         errors++;
         $display("FAIL %s after_done: done=%b busy=%b loaded=%b expected 0 0 1", tag, done, busy, loaded);
      end
   endtask

   task automatic check_contents(input string tag);
      logic [7:0] exp;
      for (int i = 0; i < (1 << IW); i++) begin
         @(negedge clk);
         rd_idx = i[IW-1:0];
         #1;
         exp = 8'h00;
         if (i < NB) exp = exp_bias[i];
         checks++;
         if (rd_bias !== exp) begin
            errors++;
            $display("FAIL %s rd_bias[%0d]: got %h expected %h", tag, i, rd_bias, exp);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (readM !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || loaded !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: readM=%b busy=%b done=%b loaded=%b err=%b expected all 0",
                  readM, busy, done, loaded, err);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_const_pattern();
      for (int i = 0; i < MEMSZ; i++) mem[i] = 8'h80;
      model_load(ptr);
      rise_cnt = 0;
      pulse_start();
      check_done_timing("const");
      checks++;
      if (rise_cnt != NB) begin
         errors++;
         $display("FAIL const readM_rises: got %0d expected %0d", rise_cnt, NB);
      end
      check_contents("const");
   endtask

   task automatic test_random_load();
      fill_random();
      model_load(ptr);
      rise_cnt = 0;
      pulse_start();
      check_done_timing("random");
      checks++;
      if (rise_cnt != NB || err !== 1'b0) begin
         errors++;
         $display("FAIL random rises_err: rises=%0d err=%b expected %0d 0", rise_cnt, err, NB);
      end
      check_contents("random");
   endtask

   task automatic test_start_ignored();
      fill_random();
      model_load(ptr);
      rise_cnt = 0;
      pulse_start();
      while (cyc < s_edge + 30) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_done_timing("restart");
      checks++;
      if (rise_cnt != NB) begin
         errors++;
         $display("FAIL restart readM_rises: got %0d expected %0d", rise_cnt, NB);
      end
      check_contents("restart");
   endtask

   task automatic test_timeout_req();
      mem_mode = 1;
      rise_cnt = 0;
      pulse_start();
      while (cyc < s_edge + TO) @(negedge clk);
      checks++;
      if (err !== 1'b0 || readM !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL to_req before: err=%b readM=%b busy=%b expected 0 1 1", err, readM, busy);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || readM !== 1'b0 || busy !== 1'b0 || loaded !== 1'b0) begin
         errors++;
         $display("FAIL to_req at: err=%b readM=%b busy=%b loaded=%b expected 1 0 0 0",
                  err, readM, busy, loaded);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (err !== 1'b1 || rise_cnt != 1) begin
         errors++;
         $display("FAIL to_req sticky: err=%b rises=%0d expected 1 1", err, rise_cnt);
      end
      mem_reset();
      check_contents("to_req");
   endtask

   task automatic test_timeout_rel();
      int p0;
      fill_random();
      p0 = ptr;
      mem_mode = 2;
      rise_cnt = 0;
      pulse_start();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL to_rel err_cleared: got %b expected 0", err);
      end
      while (cyc < s_edge + 3 + TO) @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b1 || readM !== 1'b0) begin
         errors++;
         $display("FAIL to_rel before: err=%b busy=%b readM=%b expected 0 1 0", err, busy, readM);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || readM !== 1'b0 || loaded !== 1'b0) begin
         errors++;
         $display("FAIL to_rel at: err=%b busy=%b readM=%b loaded=%b expected 1 0 0 0",
                  err, busy, readM, loaded);
      end
      checks++;
      if (rise_cnt != 1) begin
         errors++;
         $display("FAIL to_rel readM_rises: got %0d expected 1", rise_cnt);
      end
      exp_bias[0] = mem[p0 % MEMSZ];
      mem_reset();
      check_contents("to_rel");
   endtask

   task automatic test_reset_mid_load();
      fill_random();
      pulse_start();
      while (cyc < s_edge + 40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (readM !== 1'b0 || busy !== 1'b0 || loaded !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL midrst outputs: readM=%b busy=%b loaded=%b err=%b done=%b expected all 0",
                  readM, busy, loaded, err, done);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      mem_reset();
      fill_random();
      model_load(ptr);
      rise_cnt = 0;
      pulse_start();
      check_done_timing("midrst");
      checks++;
      if (rise_cnt != NB || err !== 1'b0) begin
         errors++;
         $display("FAIL midrst rises_err: rises=%0d err=%b expected %0d 0", rise_cnt, err, NB);
      end
      check_contents("midrst");
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_const_pattern();
      test_random_load();
      test_start_ignored();
      test_timeout_req();
      test_timeout_rel();
      test_reset_mid_load();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/br_bias_loader.md
# br_bias_loader

Fetches the branch bias vector from the bias memory over the 4-phase readM/ready handshake and stores it in an internal register file. After a load completes, the LSTM branch datapath reads the stored bias bytes through a random-access port. The block sits directly downstream of the bias memory and upstream of the branch gate adders. It owns sequencing, synchronisation of `ready`, timeout detection and load-complete signalling.

## Interface
- `NUM_BIAS`, 256: number of bias bytes fetched per load.
- `IDX_W`, 8: width of index and count; `2**IDX_W >= NUM_BIAS`.
- `TIMEOUT`, 1023: cycles allowed in a single handshake phase before an error is flagged.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load. Ignored while `busy`.
- `readM` out 1: request to the bias memory. Registered.
- `ready` in 1: memory acknowledge. Asynchronous to `clk`; passed through a 2-flop synchroniser internally, giving `ready_s`.
- `data` in 8: memory byte. Stable while `ready` is high.
- `rd_idx` in IDX_W: register-file read index.
- `rd_bias` out 8: combinational output, `bias[rd_idx]`. Index ≥ NUM_BIAS returns 8'h00.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse when the last byte has been written.
- `loaded` out 1: register file holds a complete vector.
- `err` out 1: sticky handshake-timeout flag.

## Operation
- Reset values:
  - `readM`=0, `busy`=0, `done`=0, `loaded`=0, `err`=0.
  - Count=0, timer=0, synchroniser flops=0, state=IDLE.
  - Register-file contents are not reset.
- IDLE:
  - On `start`: clear `loaded` and `err`, set count=0, go to REQ.
- REQ:
  - `readM`=1.
  - If `ready_s`=1: write `data` to `bias[count]`, go to REL.
- REL:
  - `readM`=0.
  - If `ready_s`=0 and count==NUM_BIAS-1: go to DONE.
  - If `ready_s`=0 otherwise: increment count, go to REQ.
- DONE:
  - `done`=1 for one cycle, `loaded`=1, go to IDLE.
- Timeout:
  - The timer clears on every state change and increments every cycle spent in REQ or REL.
  - When the timer reaches TIMEOUT: set `err`=1, force `readM`=0, go to IDLE. `loaded` stays 0.
- `busy`=1 in REQ, REL and DONE.
- Count and timer are unsigned and saturate-free. Count never exceeds NUM_BIAS-1.
- The memory's address pointer has no reset. A load aborted by reset or timeout and then restarted resumes at the memory's current address. System software reissues a memory reset in that case; this block does not compensate.
- Reset during a load: at the next edge `readM` drops to 0 and all state returns to reset values. Partially written entries remain but `loaded`=0.
- `start` coincident with `rst`: reset wins.

## Timing
- `readM` is registered and changes on the edge that enters or leaves REQ.
- `ready` to `ready_s` latency is 2 edges.
- Per byte, with the memory responding within one clock period (clk period ≥ 2 memory delay units):
  - E0: enter REQ, `readM` rises.
  - E3: REQ sees `ready_s`; byte written; `readM` falls.
  - E6: REL sees `ready_s`=0 and leaves.
  - Total: 6 cycles per byte.
- Full load: the `start` edge enters REQ. `done` goes high 6*NUM_BIAS+1 cycles after the `start` edge (1537 for the default) and stays high exactly 1 cycle. `loaded` rises on the same edge as `done` and stays high until the next `start` or `rst`.
- `rd_bias` reflects a write on the edge after the write edge.
- `err` rises on the edge where the timer equals TIMEOUT. It holds until the next accepted `start` or `rst`.

## Test plan
- Default load against a memory of 256×8'h80: `start` -> `done` one cycle at +1537 edges. `loaded`=1. `rd_bias` returns 8'h80 for indices 0..255 and 8'h00 for index 256 (when IDX_W is widened to 9).
- Incrementing-pattern memory (`mem[i]`=i) with NUM_BIAS=4 -> `rd_bias[0..3]` = 00,01,02,03. Exactly 4 `readM` rising edges. `done` at +25.
- `start` pulsed again mid-load at cycle 100 -> ignored. The `readM` rise count still equals NUM_BIAS and `done` timing is unchanged.
- Memory with `ready` held 0, TIMEOUT=15 -> `err`=1 16 cycles after `readM` rises. `readM`=0 and `busy`=0 on the next cycle. `loaded`=0.
- Memory with `ready` stuck high after the first byte -> timeout in REL: `err`=1, state IDLE, exactly one byte written.
- `rst` asserted at cycle 40 of a load -> on the next edge `readM`=0, `busy`=0, `loaded`=0, `err`=0. A following `start` completes a normal load (the memory model is reset alongside).
